// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for the multi-cycle MIPS datapath. Steps each
//   instruction through fetch, decode, execute, memory and write-back,
//   drives the datapath strobes and mux selects, and produces the 4-bit
//   aluop class for the ALU control decoder.
//
//   Optional feature macro: MC_BGTZ_EN
//     defined   : opcode 000111 (bgtz) dispatches to BRANCH with aluop 0011
//     undefined : opcode 000111 is illegal and dispatches to TRAP
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     opcode, funct       IR fields (opcode read in DECODE, funct in RWB)
//     mem_rdy             memory completed the current access this cycle
//     br_cond             ALU branch condition flag
//     pc_we, pc_src       PC write strobe and source select
//     iord, mem_rd/mem_wr memory address select and requests
//     ir_we               instruction register load
//     reg_dst, mem_to_reg register write destination / source selects
//     reg_we              register file write
//     alu_src_a/_b, aluop ALU operand selects and operation class
//     retire              pulse in the last cycle of each instruction
//     illegal             sticky flag, set on entry to TRAP
//     state               current state encoding (debug)
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_rdy,
  input  logic       br_cond,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_we,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] aluop,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB   = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state_q, state_d;
  // Opcode class remembered from DECODE so later states need not re-read IR.
  logic   is_sw_q, is_sw_d;
  logic   is_bgtz_q, is_bgtz_d;
  logic   illegal_q, illegal_d;

  always_comb begin
    state_d   = state_q;
    is_sw_d   = is_sw_q;
    is_bgtz_d = is_bgtz_q;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        is_sw_d = (opcode == OP_SW);
`ifdef MC_BGTZ_EN
        is_bgtz_d = (opcode == OP_BGTZ);
`else
        is_bgtz_d = 1'b0;
`endif
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REXEC;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_BGTZ_EN
          OP_BGTZ:      state_d = S_BRANCH;
`endif
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_IEXEC;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      is_sw_q   <= 1'b0;
      is_bgtz_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_sw_q   <= is_sw_d;
      is_bgtz_q <= is_bgtz_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore decode of the current state; only the mem_rdy/br_cond/funct
  // qualified strobes look at inputs.
  logic pc_we_c, mem_rd_c, mem_wr_c, ir_we_c, reg_we_c;

  always_comb begin
    pc_we_c    = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_rd_c   = 1'b0;
    mem_wr_c   = 1'b0;
    ir_we_c    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_we_c   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    aluop      = 4'b0000;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd_c  = 1'b1;
        alu_src_b = 2'b01;
        ir_we_c   = mem_rdy;
        pc_we_c   = mem_rdy;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR, S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_rd_c = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_we_c   = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_wr_c = 1'b1;
        iord     = 1'b1;
        retire   = mem_rdy;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        aluop     = 4'b0010;
      end
      S_RWB: begin
        reg_dst  = 1'b1;
        retire   = 1'b1;
        // funct 000000 is treated as a no-op: nothing is written.
        reg_we_c = (funct != 6'b000000);
      end
      S_IWB: begin
        reg_we_c = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = 2'b01;
        retire    = 1'b1;
        pc_we_c   = br_cond;
`ifdef MC_BGTZ_EN
        aluop     = is_bgtz_q ? 4'b0011 : 4'b0001;
`else
        aluop     = 4'b0001;
`endif
      end
      S_JUMP: begin
        pc_we_c = 1'b1;
        pc_src  = 2'b10;
        retire  = 1'b1;
      end
      default: ;
    endcase
  end

  // Write/request strobes are killed the instant reset asserts so an
  // in-flight instruction cannot complete a partial write.
  assign pc_we   = pc_we_c  & rst_n;
  assign mem_rd  = mem_rd_c & rst_n;
  assign mem_wr  = mem_wr_c & rst_n;
  assign ir_we   = ir_we_c  & rst_n;
  assign reg_we  = reg_we_c & rst_n;
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       mem_rdy, br_cond;
  logic       pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg;
  logic       reg_we, alu_src_a, retire, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] aluop, state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .mem_rdy(mem_rdy), .br_cond(br_cond), .pc_we(pc_we), .pc_src(pc_src),
    .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_we(ir_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_we(reg_we),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .retire(retire), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BGTZ = 6'b000111, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;

  typedef struct packed {
    logic [3:0] st;
    logic       illegal, retire, mem_rd, mem_wr, ir_we, pc_we, reg_we;
    logic       iord, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] aluop;
  } outs_t;

  typedef struct packed {
    logic       mrdy, brc;
    logic [5:0] op, fn;
  } stim_t;

  stim_t stim_q[$];
  outs_t exp_q[$];
  string tag_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic outs_t blank(input logic [3:0] st);
    outs_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic outs_t sample();
    outs_t g;
    g.st = state;         g.illegal = illegal;   g.retire = retire;
    g.mem_rd = mem_rd;    g.mem_wr = mem_wr;     g.ir_we = ir_we;
    g.pc_we = pc_we;      g.reg_we = reg_we;     g.iord = iord;
    g.reg_dst = reg_dst;  g.mem_to_reg = mem_to_reg;
    g.alu_src_a = alu_src_a; g.pc_src = pc_src;  g.alu_src_b = alu_src_b;
    g.aluop = aluop;
    return g;
  endfunction

  task automatic push(input string tag, input logic mrdy, input logic brc,
                      input logic [5:0] op, input logic [5:0] fn, input outs_t e);
    stim_t s;
    s.mrdy = mrdy; s.brc = brc; s.op = op; s.fn = fn;
    stim_q.push_back(s);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Expected-cycle generators: one entry per clock of each instruction.
  task automatic gen_fetch(input string nm, input logic [5:0] op, input int waits);
    outs_t e;
    for (int i = 0; i < waits; i++) begin
      e = blank(4'd0); e.mem_rd = 1'b1; e.alu_src_b = 2'b01;
      push({nm, ".fetchwait"}, 1'b0, 1'b0, op, 6'd0, e);
    end
    e = blank(4'd0); e.mem_rd = 1'b1; e.alu_src_b = 2'b01;
    e.ir_we = 1'b1; e.pc_we = 1'b1;
    push({nm, ".fetch"}, 1'b1, 1'b0, op, 6'd0, e);
    e = blank(4'd1); e.alu_src_b = 2'b11;
    push({nm, ".decode"}, 1'b1, 1'b0, op, 6'd0, e);
  endtask

  task automatic gen_lw(input string nm, input int fw, input int rw);
    outs_t e;
    gen_fetch(nm, OP_LW, fw);
    e = blank(4'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    push({nm, ".memadr"}, 1'b1, 1'b0, OP_LW, 6'd0, e);
    e = blank(4'd3); e.mem_rd = 1'b1; e.iord = 1'b1;
    for (int i = 0; i < rw; i++) push({nm, ".memrdwait"}, 1'b0, 1'b0, OP_LW, 6'd0, e);
    push({nm, ".memrd"}, 1'b1, 1'b0, OP_LW, 6'd0, e);
    e = blank(4'd4); e.reg_we = 1'b1; e.mem_to_reg = 1'b1; e.retire = 1'b1;
    push({nm, ".memwb"}, 1'b1, 1'b0, OP_LW, 6'd0, e);
  endtask

  task automatic gen_sw(input string nm, input int ww);
    outs_t e;
    gen_fetch(nm, OP_SW, 0);
    e = blank(4'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    push({nm, ".memadr"}, 1'b1, 1'b0, OP_SW, 6'd0, e);
    e = blank(4'd5); e.mem_wr = 1'b1; e.iord = 1'b1;
    for (int i = 0; i < ww; i++) push({nm, ".memwrwait"}, 1'b0, 1'b0, OP_SW, 6'd0, e);
    e.retire = 1'b1;
    push({nm, ".memwr"}, 1'b1, 1'b0, OP_SW, 6'd0, e);
  endtask

  task automatic gen_r(input string nm, input logic [5:0] fn);
    outs_t e;
    gen_fetch(nm, OP_R, 0);
    e = blank(4'd6); e.alu_src_a = 1'b1; e.aluop = 4'b0010;
    push({nm, ".rexec"}, 1'b1, 1'b0, OP_R, fn, e);
    e = blank(4'd7); e.reg_dst = 1'b1; e.retire = 1'b1; e.reg_we = (fn != 6'd0);
    push({nm, ".rwb"}, 1'b1, 1'b0, OP_R, fn, e);
  endtask

  task automatic gen_br(input string nm, input logic [5:0] op, input logic c);
    outs_t e;
    gen_fetch(nm, op, 0);
    e = blank(4'd8); e.alu_src_a = 1'b1; e.pc_src = 2'b01; e.retire = 1'b1;
    e.aluop = (op == OP_BGTZ) ? 4'b0011 : 4'b0001;
    e.pc_we = c;
    push({nm, ".branch"}, 1'b1, c, op, 6'd0, e);
  endtask

  task automatic gen_j(input string nm);
    outs_t e;
    gen_fetch(nm, OP_J, 0);
    e = blank(4'd9); e.pc_we = 1'b1; e.pc_src = 2'b10; e.retire = 1'b1;
    push({nm, ".jump"}, 1'b1, 1'b0, OP_J, 6'd0, e);
  endtask

  task automatic gen_addi(input string nm);
    outs_t e;
    gen_fetch(nm, OP_ADDI, 0);
    e = blank(4'd10); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    push({nm, ".iexec"}, 1'b1, 1'b0, OP_ADDI, 6'd0, e);
    e = blank(4'd11); e.reg_we = 1'b1; e.retire = 1'b1;
    push({nm, ".iwb"}, 1'b1, 1'b0, OP_ADDI, 6'd0, e);
  endtask

  task automatic gen_trap(input string nm, input logic [5:0] op, input int n);
    outs_t e;
    gen_fetch(nm, op, 0);
    e = blank(4'd12); e.illegal = 1'b1;
    for (int i = 0; i < n; i++) push({nm, ".trap"}, 1'b1, 1'b0, op, 6'd0, e);
  endtask

  // Called on a falling edge: drive, let decode settle, compare, advance.
  task automatic run_queue();
    stim_t s;
    outs_t e;
    string t;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      mem_rdy = s.mrdy; br_cond = s.brc; opcode = s.op; funct = s.fn;
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, {9'd0, sample()}, {9'd0, e});
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_rdy = 1'b1; br_cond = 1'b0; opcode = '0; funct = '0;
    @(negedge clk); @(negedge clk);
    chk("rst.state",   {28'd0, state}, 32'd0);
    chk("rst.illegal", {31'd0, illegal}, 32'd0);
    chk("rst.mem_rd",  {31'd0, mem_rd}, 32'd0);
    chk("rst.ir_we",   {31'd0, ir_we}, 32'd0);
    chk("rst.pc_we",   {31'd0, pc_we}, 32'd0);
    rst_n = 1'b1;

    gen_lw("lw", 0, 0);
    gen_sw("sw", 3);
    gen_r("radd", 6'b100000);
    gen_r("rnop", 6'b000000);
    gen_br("beqT", OP_BEQ, 1'b1);
    gen_br("beqN", OP_BEQ, 1'b0);
    gen_addi("addi");
    gen_j("j");
    gen_lw("lwwait", 2, 1);
`ifdef MC_BGTZ_EN
    gen_br("bgtzT", OP_BGTZ, 1'b1);
    gen_br("bgtzN", OP_BGTZ, 1'b0);
`endif
    // lw stopped in MEMRD with memory still busy; reset follows.
    gen_fetch("lwabort", OP_LW, 0);
    begin
      outs_t e;
      e = blank(4'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
      push("lwabort.memadr", 1'b1, 1'b0, OP_LW, 6'd0, e);
      e = blank(4'd3); e.mem_rd = 1'b1; e.iord = 1'b1;
      push("lwabort.memrd", 1'b0, 1'b0, OP_LW, 6'd0, e);
    end
    run_queue();

    // Reset mid-MEMRD: memory reports ready just as reset hits.
    mem_rdy = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("abort.state",  {28'd0, state}, 32'd0);
    chk("abort.mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("abort.reg_we", {31'd0, reg_we}, 32'd0);
    @(posedge clk); #1;
    chk("abort.reg_we2", {31'd0, reg_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MC_BGTZ_EN
    gen_trap("illop", 6'b111111, 3);
`else
    gen_trap("bgtzoff", OP_BGTZ, 3);
`endif
    run_queue();

    rst_n = 1'b0;
    #1;
    chk("trapclr.illegal", {31'd0, illegal}, 32'd0);
    chk("trapclr.state",   {28'd0, state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gen_j("jpost");
    run_queue();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
